// File: rtl/bank_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : bank_cmd_scheduler_if
// Brief    : Request / command / response bundle around bank_cmd_scheduler.
//            The scheduler connects through the slave modport; the front end
//            and command_sender side (or a bench) use the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface bank_cmd_scheduler_if #(
  parameter int BANK_GROUPS     = 2,
  parameter int BANKS_PER_GROUP = 4,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 4,
  parameter int PADDR_BITS      = 64
);
  localparam int c_BG_W = $clog2(BANK_GROUPS);
  localparam int c_BA_W = $clog2(BANKS_PER_GROUP);

  // Request side
  logic                    req_valid_in;
  logic                    req_ready_out;
  logic                    req_write_in;
  logic [PADDR_BITS-1:0]   req_addr_in;
  logic [7:0][63:0]        req_wdata_in;

  // Command side (towards command_sender)
  logic                    cmd_valid_out;
  logic [2:0]              cmd_out;
  logic [c_BG_W-1:0]       cmd_bg_out;
  logic [c_BA_W-1:0]       cmd_ba_out;
  logic [ROW_BITS-1:0]     cmd_row_out;
  logic [COL_BITS-1:0]     cmd_col_out;
  logic [7:0][63:0]        cmd_wdata_out;
  logic [7:0][63:0]        rd_data_in;

  // Response side
  logic                    resp_valid_out;
  logic                    resp_write_out;
  logic [7:0][63:0]        resp_rdata_out;
  logic                    busy_out;

  modport slave (
    input  req_valid_in, req_write_in, req_addr_in, req_wdata_in, rd_data_in,
    output req_ready_out, cmd_valid_out, cmd_out, cmd_bg_out, cmd_ba_out,
           cmd_row_out, cmd_col_out, cmd_wdata_out,
           resp_valid_out, resp_write_out, resp_rdata_out, busy_out
  );

  modport master (
    output req_valid_in, req_write_in, req_addr_in, req_wdata_in, rd_data_in,
    input  req_ready_out, cmd_valid_out, cmd_out, cmd_bg_out, cmd_ba_out,
           cmd_row_out, cmd_col_out, cmd_wdata_out,
           resp_valid_out, resp_write_out, resp_rdata_out, busy_out
  );
endinterface
`default_nettype wire

// File: rtl/bank_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bank_cmd_scheduler
// Brief    : Open-page DRAM command scheduler. Accepts one request at a time,
//            decodes bank group / bank / row / column, tracks the open row of
//            each bank and issues the minimal PRE/ACT/RD/WR sequence with the
//            configured latencies. One response per request.
//            Interface parameters must match the module parameters.
// Revision : 1.0 - initial release
// ============================================================================
module bank_cmd_scheduler #(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BURST_CYCLES       = 4,
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int PADDR_BITS         = 64
) (
  input  wire logic             clk_in,
  input  wire logic             rst_in,
  bank_cmd_scheduler_if.slave   bus
);
  // Field widths and address bit positions
  localparam int c_BG_W     = $clog2(BANK_GROUPS);
  localparam int c_BA_W     = $clog2(BANKS_PER_GROUP);
  localparam int c_IDX_W    = c_BG_W + c_BA_W;
  localparam int c_NBANK    = 1 << c_IDX_W;
  localparam int c_BA_LO    = 3 + COL_BITS;
  localparam int c_BG_LO    = c_BA_LO + c_BA_W;
  localparam int c_ROW_LO   = c_BG_LO + c_BG_W;
  localparam int c_ADDR_TOP = c_ROW_LO + ROW_BITS;

  // Timer sizing: the longest wait is a read's CAS + burst
  localparam int c_RD_LAT = CAS_LATENCY + BURST_CYCLES;
  localparam int c_TMAX0  = (c_RD_LAT > ACTIVATION_LATENCY) ? c_RD_LAT : ACTIVATION_LATENCY;
  localparam int c_TMAX   = (c_TMAX0 > PRECHARGE_LATENCY) ? c_TMAX0 : PRECHARGE_LATENCY;
  localparam int c_TMR_W  = $clog2(c_TMAX + 1);
  localparam logic [c_TMR_W-1:0] c_T_RD  = c_TMR_W'(c_RD_LAT);
  localparam logic [c_TMR_W-1:0] c_T_WR  = c_TMR_W'(BURST_CYCLES);
  localparam logic [c_TMR_W-1:0] c_T_ACT = c_TMR_W'(ACTIVATION_LATENCY);
  localparam logic [c_TMR_W-1:0] c_T_PRE = c_TMR_W'(PRECHARGE_LATENCY);
  localparam logic [c_TMR_W-1:0] c_T_ONE = c_TMR_W'(1);

  // Command encodings
  localparam logic [2:0] c_CMD_RD  = 3'b000;
  localparam logic [2:0] c_CMD_WR  = 3'b001;
  localparam logic [2:0] c_CMD_ACT = 3'b010;
  localparam logic [2:0] c_CMD_PRE = 3'b011;

  // FSM states
  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_DECIDE    = 3'd1;
  localparam logic [2:0] c_ST_PRE_WAIT  = 3'd2;
  localparam logic [2:0] c_ST_ACT_WAIT  = 3'd3;
  localparam logic [2:0] c_ST_DATA_WAIT = 3'd4;
  localparam logic [2:0] c_ST_RESP      = 3'd5;

  logic [2:0]           r_state, w_state_nxt;
  logic [c_TMR_W-1:0]   r_timer;
  logic                 w_timer_ld;
  logic [c_TMR_W-1:0]   w_timer_val;
  logic                 w_issue;
  logic [2:0]           w_issue_cmd;

  // Latched request
  logic                 r_write;
  logic [7:0][63:0]     r_wdata;
  logic [c_BG_W-1:0]    r_bg;
  logic [c_BA_W-1:0]    r_ba;
  logic [ROW_BITS-1:0]  r_row;
  logic [COL_BITS-1:0]  r_col;

  // Registered command outputs
  logic                 r_cmd_valid;
  logic [2:0]           r_cmd;
  logic [c_BG_W-1:0]    r_cmd_bg;
  logic [c_BA_W-1:0]    r_cmd_ba;
  logic [ROW_BITS-1:0]  r_cmd_row;
  logic [COL_BITS-1:0]  r_cmd_col;
  logic [7:0][63:0]     r_cmd_wdata;

  // Bank table and held response data
  logic [c_NBANK-1:0]   r_bank_open;
  logic [ROW_BITS-1:0]  r_bank_row [c_NBANK];
  logic [7:0][63:0]     r_resp_rdata;

  logic                 w_accept;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_bank_open;
  logic                 w_row_hit;
  logic [2:0]           w_data_cmd;
  logic [c_TMR_W-1:0]   w_data_lat;

  assign w_accept    = (r_state == c_ST_IDLE) && bus.req_valid_in;
  assign w_idx       = {r_bg, r_ba};
  assign w_bank_open = r_bank_open[w_idx];
  assign w_row_hit   = (r_bank_row[w_idx] == r_row);
  assign w_data_cmd  = r_write ? c_CMD_WR : c_CMD_RD;
  assign w_data_lat  = r_write ? c_T_WR : c_T_RD;

  // Low (byte-in-beat) address bits and bits above the row are not decoded
  generate
    if (PADDR_BITS > c_ADDR_TOP) begin : g_addr_hi
      logic w_addr_unused;
      assign w_addr_unused = ^{bus.req_addr_in[2:0], bus.req_addr_in[PADDR_BITS-1:c_ADDR_TOP]};
    end else begin : g_addr_exact
      logic w_addr_unused;
      assign w_addr_unused = ^bus.req_addr_in[2:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, plus which command (if any) gets registered and timer reload
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_issue_cmd = c_CMD_RD;
    w_timer_ld  = 1'b0;
    w_timer_val = '0;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.req_valid_in) w_state_nxt = c_ST_DECIDE;
      end
      c_ST_DECIDE: begin
        w_issue    = 1'b1;
        w_timer_ld = 1'b1;
        if (w_bank_open && w_row_hit) begin
          w_issue_cmd = w_data_cmd;
          w_timer_val = w_data_lat;
          w_state_nxt = c_ST_DATA_WAIT;
        end else if (!w_bank_open) begin
          w_issue_cmd = c_CMD_ACT;
          w_timer_val = c_T_ACT;
          w_state_nxt = c_ST_ACT_WAIT;
        end else begin
          w_issue_cmd = c_CMD_PRE;
          w_timer_val = c_T_PRE;
          w_state_nxt = c_ST_PRE_WAIT;
        end
      end
      c_ST_PRE_WAIT: begin
        // Register ACTIVATE so it appears the cycle the timer would hit 0
        if (r_timer <= c_T_ONE) begin
          w_issue     = 1'b1;
          w_issue_cmd = c_CMD_ACT;
          w_timer_ld  = 1'b1;
          w_timer_val = c_T_ACT;
          w_state_nxt = c_ST_ACT_WAIT;
        end
      end
      c_ST_ACT_WAIT: begin
        if (r_timer <= c_T_ONE) begin
          w_issue     = 1'b1;
          w_issue_cmd = w_data_cmd;
          w_timer_ld  = 1'b1;
          w_timer_val = w_data_lat;
          w_state_nxt = c_ST_DATA_WAIT;
        end
      end
      c_ST_DATA_WAIT: begin
        if (r_timer <= c_T_ONE) w_state_nxt = c_ST_RESP;
      end
      c_ST_RESP: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM outputs; read data passes straight through during RESP, held otherwise
  always_comb begin
    bus.req_ready_out  = (r_state == c_ST_IDLE);
    bus.busy_out       = (r_state != c_ST_IDLE);
    bus.resp_valid_out = (r_state == c_ST_RESP);
    bus.resp_write_out = (r_state == c_ST_RESP) && r_write;
    bus.resp_rdata_out = ((r_state == c_ST_RESP) && !r_write) ? bus.rd_data_in : r_resp_rdata;
  end

  // Request latch on handshake
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_write <= 1'b0;
      r_wdata <= '0;
      r_bg    <= '0;
      r_ba    <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write_in;
      r_wdata <= bus.req_wdata_in;
      r_col   <= bus.req_addr_in[c_BA_LO-1:3];
      r_ba    <= bus.req_addr_in[c_BG_LO-1:c_BA_LO];
      r_bg    <= bus.req_addr_in[c_ROW_LO-1:c_BG_LO];
      r_row   <= bus.req_addr_in[c_ADDR_TOP-1:c_ROW_LO];
    end
  end

  // Command register and bank table, updated together so the table reflects
  // a command from the cycle it appears on the bus
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cmd_valid <= 1'b0;
      r_cmd       <= c_CMD_RD;
      r_cmd_bg    <= '0;
      r_cmd_ba    <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_cmd_wdata <= '0;
      r_bank_open <= '0;
      for (int i = 0; i < c_NBANK; i++) r_bank_row[i] <= '0;
    end else begin
      r_cmd_valid <= w_issue;
      if (w_issue) begin
        r_cmd       <= w_issue_cmd;
        r_cmd_bg    <= r_bg;
        r_cmd_ba    <= r_ba;
        r_cmd_row   <= r_row;
        r_cmd_col   <= r_col;
        r_cmd_wdata <= r_wdata;
        if (w_issue_cmd == c_CMD_ACT) begin
          r_bank_open[w_idx] <= 1'b1;
          r_bank_row[w_idx]  <= r_row;
        end else if (w_issue_cmd == c_CMD_PRE) begin
          r_bank_open[w_idx] <= 1'b0;
        end
      end
    end
  end

  // Latency timer: reload on issue, otherwise count down and stick at 0
  always_ff @(posedge clk_in) begin
    if (rst_in)                r_timer <= '0;
    else if (w_timer_ld)       r_timer <= w_timer_val;
    else if (r_timer != '0)    r_timer <= r_timer - c_T_ONE;
  end

  // Keep the last read line so resp_rdata_out is stable after a read response
  always_ff @(posedge clk_in) begin
    if (rst_in)                                     r_resp_rdata <= '0;
    else if ((r_state == c_ST_RESP) && !r_write)    r_resp_rdata <= bus.rd_data_in;
  end

  assign bus.cmd_valid_out = r_cmd_valid;
  assign bus.cmd_out       = r_cmd;
  assign bus.cmd_bg_out    = r_cmd_bg;
  assign bus.cmd_ba_out    = r_cmd_ba;
  assign bus.cmd_row_out   = r_cmd_row;
  assign bus.cmd_col_out   = r_cmd_col;
  assign bus.cmd_wdata_out = r_cmd_wdata;

endmodule
`default_nettype wire
